// File: rtl/vote_button_capture.sv
`default_nettype none
// ============================================================================
//  Module   : vote_button_capture
//  Purpose  : Synchronise and debounce candidate push-buttons, then issue one
//             candidate ID per clean press over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module vote_button_capture #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic               clk_100MHz,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               vote_enable,
    output logic               vote_valid,
    output logic [1:0]         vote_cand,
    input  logic               vote_ready,
    output logic               conflict,
    output logic [NUM_BTN-1:0] btn_db
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_PENDING = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    logic [1:0]         r_warm;
    logic [CNT_W-1:0]   r_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] r_btn_db;
    logic [NUM_BTN-1:0] r_btn_db_prev;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_cand;
    logic [1:0]         w_cand_nxt;
    logic               r_conflict;
    logic               w_conflict_nxt;
    logic [NUM_BTN-1:0] w_new_press;
    logic               w_any_press;
    logic               w_db_zero;
    logic               w_db_one;
    logic [1:0]         w_idx;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_warm  <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_warm  <= {r_warm[0], 1'b1};
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_cnt[i] <= '0;
            end
            r_btn_db      <= '0;
            r_btn_db_prev <= '0;
        end else begin
            r_btn_db_prev <= r_btn_db;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (r_sync2[i] == r_btn_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_CNT_MAX) begin
                    r_cnt[i]    <= '0;
                    r_btn_db[i] <= ~r_btn_db[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_new_press = r_btn_db & ~r_btn_db_prev;
    assign w_any_press = |w_new_press;
    assign w_db_zero   = (r_btn_db == '0);
    assign w_db_one    = !w_db_zero && ((r_btn_db & (r_btn_db - NUM_BTN'(1))) == '0);

    always_comb begin
        w_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (r_btn_db[i]) begin
                w_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cand     <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cand     <= w_cand_nxt;
            r_conflict <= w_conflict_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cand_nxt     = r_cand;
        w_conflict_nxt = 1'b0;
        case (r_state)
            // A button already held (even still in the synchroniser) must be
            // released before arming, so it cannot become a vote later.
            S_IDLE: begin
                if (vote_enable && w_db_zero && (r_sync2 == '0) && r_warm[1]) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!vote_enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_any_press && w_db_one) begin
                    w_cand_nxt  = w_idx;
                    w_state_nxt = S_PENDING;
                end else if (w_any_press) begin
                    w_conflict_nxt = 1'b1;
                    w_state_nxt    = S_LOCKOUT;
                end
            end
            S_PENDING: begin
                if (vote_ready) begin
                    w_state_nxt = S_LOCKOUT;
                end
            end
            S_LOCKOUT: begin
                if (w_db_zero) begin
                    w_state_nxt = vote_enable ? S_ARMED : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign vote_valid = (r_state == S_PENDING);
    assign vote_cand  = r_cand;
    assign conflict   = r_conflict;
    assign btn_db     = r_btn_db;

endmodule
`default_nettype wire

// File: tb/tb_vote_button_capture.sv
`default_nettype none
// Bench for vote_button_capture: randomized directed steps against a
// history-window debounce model and a vote/conflict scoreboard.
module tb_vote_button_capture;

    localparam int NB = 4;
    localparam int DB = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic          vote_enable = 1'b0;
    logic          vote_ready = 1'b0;
    logic          vote_valid;
    logic [1:0]    vote_cand;
    logic          conflict;
    logic [NB-1:0] btn_db;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vote_button_capture #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CW)
    ) dut (
        .clk_100MHz (clk),
        .reset_n    (rst_n),
        .btn_raw    (btn_raw),
        .vote_enable(vote_enable),
        .vote_valid (vote_valid),
        .vote_cand  (vote_cand),
        .vote_ready (vote_ready),
        .conflict   (conflict),
        .btn_db     (btn_db)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Debounced level flips once the raw level (seen two cycles late) has
    // disagreed with it for DB consecutive samples.
    function automatic logic [NB-1:0] next_db(input logic [NB-1:0] cur,
                                              input logic [NB-1:0] h [0:DB]);
        logic [NB-1:0] r;
        r = cur;
        for (int b = 0; b < NB; b++) begin
            int diffs;
            diffs = 0;
            for (int k = 1; k <= DB; k++) begin
                if (h[k][b] != cur[b]) diffs++;
            end
            if (diffs == DB) r[b] = ~cur[b];
        end
        return r;
    endfunction

    logic [NB-1:0] hist [0:DB];
    logic [NB-1:0] mdb;
    logic          db1_q;
    logic [1:0]    got[$];
    int            exp_votes[$];
    int            n_conf = 0;
    int            n_rise1 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= DB; k++) hist[k] <= '0;
            mdb   <= '0;
            db1_q <= 1'b0;
        end else begin
            mdb     <= next_db(mdb, hist);
            hist[0] <= btn_raw;
            for (int k = 1; k <= DB; k++) hist[k] <= hist[k-1];
            if (vote_valid && vote_ready) got.push_back(vote_cand);
            if (conflict) n_conf <= n_conf + 1;
            if (btn_db[1] && !db1_q) n_rise1 <= n_rise1 + 1;
            db1_q <= btn_db[1];
        end
    end

    always @(negedge clk) begin
        if (rst_n) chk("btn_db_model", btn_db, mdb);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cyc, output int lat);
        lat = 0;
        while (!vote_valid && lat < max_cyc) begin
            tick(1);
            lat++;
        end
    endtask

    task automatic release_all();
        btn_raw = '0;
        tick(DB + 6);
    endtask

    task automatic press_vote(input int idx, input int rdy_dly, input bit drop_en);
        int lat;
        btn_raw = NB'(1) << idx;
        wait_valid(40, lat);
        chk("valid_rise", vote_valid, 1'b1);
        chk("press_latency", (lat >= 11 && lat <= 12), 1'b1);
        chk("cand", vote_cand, idx[1:0]);
        if (drop_en) vote_enable = 1'b0;
        for (int i = 0; i < rdy_dly; i++) begin
            tick(1);
            chk("hold_valid", vote_valid, 1'b1);
            chk("hold_cand", vote_cand, idx[1:0]);
        end
        vote_ready = 1'b1;
        tick(1);
        vote_ready = 1'b0;
        chk("valid_drop", vote_valid, 1'b0);
        exp_votes.push_back(idx);
        tick($urandom_range(10, 40));
        chk("no_repeat", vote_valid, 1'b0);
        release_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, a, b, c0, r0, elapsed, seg;
        bit lvl;

        // Reset with a button held: nothing may arm until it is released.
        btn_raw = 4'b0010;
        vote_enable = 1'b1;
        tick(4);
        chk("rst_db", btn_db, '0);
        chk("rst_valid", vote_valid, 1'b0);
        chk("rst_cand", vote_cand, 2'd0);
        chk("rst_conflict", conflict, 1'b0);
        rst_n = 1'b1;
        tick(40);
        chk("held_no_vote", vote_valid, 1'b0);
        chk("held_db", btn_db, 4'b0010);
        release_all();

        press_vote(2, 5, 1'b0);
        press_vote(0, $urandom_range(0, 6), 1'b0);
        repeat (3) press_vote($urandom_range(0, NB - 1), $urandom_range(0, 6), 1'b0);

        // Ready already high: accepted on the first valid cycle.
        vote_ready = 1'b1;
        a = $urandom_range(0, NB - 1);
        btn_raw = NB'(1) << a;
        wait_valid(40, lat);
        chk("rdy_first_valid", vote_valid, 1'b1);
        chk("rdy_first_cand", vote_cand, a[1:0]);
        tick(1);
        chk("rdy_first_one_cycle", vote_valid, 1'b0);
        vote_ready = 1'b0;
        exp_votes.push_back(a);
        tick(20);
        release_all();

        // Bounce on button 1 with segments shorter than the debounce window.
        r0 = n_rise1;
        elapsed = 0;
        lvl = 1'b1;
        while (elapsed < 30) begin
            btn_raw = {2'b00, lvl, 1'b0};
            seg = $urandom_range(1, DB - 1);
            tick(seg);
            elapsed += seg;
            lvl = ~lvl;
        end
        btn_raw = 4'b0010;
        wait_valid(40, lat);
        chk("bounce_valid", vote_valid, 1'b1);
        chk("bounce_cand", vote_cand, 2'd1);
        vote_ready = 1'b1;
        tick(1);
        vote_ready = 1'b0;
        exp_votes.push_back(1);
        tick(20);
        release_all();
        chk("bounce_db1_rises", n_rise1 - r0, 1);

        // Two buttons together: one conflict pulse, no vote.
        a = $urandom_range(0, NB - 1);
        b = (a + $urandom_range(1, NB - 1)) % NB;
        c0 = n_conf;
        btn_raw = (NB'(1) << a) | (NB'(1) << b);
        tick(30);
        chk("conflict_pulses", n_conf - c0, 1);
        chk("conflict_no_vote", vote_valid, 1'b0);
        release_all();
        press_vote(3, $urandom_range(0, 6), 1'b0);

        // Gating by vote_enable.
        vote_enable = 1'b0;
        btn_raw = 4'b0001;
        tick(30);
        chk("disabled_no_vote", vote_valid, 1'b0);
        release_all();
        vote_enable = 1'b1;
        tick(3);
        press_vote($urandom_range(0, NB - 1), 4, 1'b1);
        btn_raw = NB'(1) << $urandom_range(0, NB - 1);
        tick(30);
        chk("idle_after_drop", vote_valid, 1'b0);
        release_all();
        vote_enable = 1'b1;
        tick(3);

        // Asynchronous reset while a vote is pending.
        a = $urandom_range(0, NB - 1);
        btn_raw = NB'(1) << a;
        wait_valid(40, lat);
        chk("pre_rst_valid", vote_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", vote_valid, 1'b0);
        chk("async_rst_db", btn_db, '0);
        chk("async_rst_cand", vote_cand, 2'd0);
        btn_raw = '0;
        tick(2);
        rst_n = 1'b1;
        tick(DB + 6);
        chk("post_rst_quiet", vote_valid, 1'b0);
        press_vote($urandom_range(0, NB - 1), $urandom_range(0, 6), 1'b0);

        chk("vote_count", got.size(), exp_votes.size());
        for (int i = 0; i < got.size() && i < exp_votes.size(); i++) begin
            chk("vote_seq", got[i], exp_votes[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vote_button_capture.md
Name: vote_button_capture

Overview:
Input-side counterpart to the seven-segment output path: converts the raw Nexys A7 candidate push-buttons into clean, single vote events for the voting state machine. Synchronises and debounces each button, detects new presses, and presents one candidate ID per press over a valid/ready handshake. Rejects multi-button presses and locks out further input until all buttons are released.

Parameters:
NUM_BTN, 4, number of candidate buttons; candidate ID width is 2 bits, so NUM_BTN ≤ 4.
DEBOUNCE_CYCLES, 1_000_000, stable-level cycles required before a debounced level changes (10 ms at 100 MHz).
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk_100MHz  input  1  system clock, 100 MHz
reset_n  input  1  asynchronous, active-low reset
btn_raw  input  NUM_BTN  raw, asynchronous button levels; 1 = pressed
vote_enable  input  1  high while the state machine is in Voting Open
vote_valid  output  1  a vote is pending
vote_cand  output  2  candidate ID of the pending vote; index of the pressed button
vote_ready  input  1  consumer accepts the vote when vote_valid && vote_ready
conflict  output  1  one-cycle pulse when a press is rejected because more than one button is pressed
btn_db  output  NUM_BTN  debounced button levels, for LED echo

Behaviour:
- Reset (reset_n low, asynchronous): all synchroniser flops, debounce counters and btn_db go to 0. State goes to IDLE. vote_valid = 0, vote_cand = 0, conflict = 0.
- Synchroniser: two flops per bit on btn_raw. Total sync latency is 2 cycles.
- Debounce (per bit): compare the synced level with btn_db.
  - If they are equal, clear the counter.
  - Otherwise increment the counter. When it reaches DEBOUNCE_CYCLES-1, toggle btn_db and clear the counter.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches btn_db.
  - Latency from a stable raw edge to btn_db is 2 + DEBOUNCE_CYCLES cycles.
- Press detect: new_press = btn_db & ~btn_db_prev, registered one cycle.
- FSM, with transitions evaluated each clock:
  - IDLE: if vote_enable and btn_db == 0, go to ARMED. Buttons are ignored here.
  - ARMED:
    - If vote_enable = 0, go to IDLE.
    - Else if any new_press and btn_db has exactly one bit set: latch vote_cand = index of that bit, set vote_valid = 1, go to PENDING.
    - Else if any new_press and btn_db has more than one bit set: pulse conflict for 1 cycle and go to LOCKOUT. No vote is issued.
  - PENDING:
    - vote_valid and vote_cand are held stable until the handshake.
    - On vote_valid && vote_ready: clear vote_valid the next cycle and go to LOCKOUT.
    - vote_enable falling while PENDING does not drop the vote. The handshake must complete first.
  - LOCKOUT: stay until btn_db == 0, then go to ARMED if vote_enable, else go to IDLE.
- Guarantees:
  - At most one vote per press.
  - A held button never repeats.
  - Presses arriving while PENDING or LOCKOUT are discarded; they are not queued.
- Simultaneous events:
  - If new_press and the btn_db multi-bit condition occur in the same cycle, the result is conflict, not a vote.
  - If vote_ready is already high when vote_valid rises, the vote is accepted in that first cycle, so vote_valid is high for exactly 1 cycle.
- Reset mid-operation: a pending vote is discarded with no handshake. After reset_n deasserts, the FSM restarts in IDLE.
- Throughput: at most one vote per press/release cycle. Minimum spacing between votes is about 2·DEBOUNCE_CYCLES.

Test Plan (sim with DEBOUNCE_CYCLES = 8, CNT_W = 4):
1. Reset: hold reset_n = 0 with btn_raw = 4'b0010 → btn_db = 0, vote_valid = 0. Release reset with vote_enable = 1 and btn_raw held → no vote; FSM stays in IDLE until the button is released and btn_db returns to 0.
2. Single vote: in ARMED, press btn_raw[2] for 50 cycles → vote_valid rises about 11 cycles after the press, with vote_cand = 2. With vote_ready = 0 for 5 cycles then 1, vote_valid drops the cycle after the handshake. Holding the button produces no second vote. Release then press btn_raw[0] → vote_cand = 0.
3. Bounce: toggle btn_raw[1] every 3 cycles for 30 cycles, then hold high → exactly one vote with vote_cand = 1, and btn_db[1] has a single rising edge.
4. Conflict: press btn_raw[3] and btn_raw[1] together → conflict pulses once, vote_valid stays 0. Release both, then press btn_raw[3] alone → vote_cand = 3.
5. Gating: vote_enable = 0 and press btn_raw[0] → no vote. Drop vote_enable while PENDING → vote is still held until vote_ready, then the FSM returns to IDLE after release.
6. Async reset while PENDING: pulse reset_n low mid-cycle → vote_valid clears immediately, with no clock edge required.
